// File: rtl/wb_interconnect_arb.sv
// Per-target round-robin arbiter for the Wishbone N x N interconnect.
// Grants are combinational from req, held until ack or abandon, then rotate.
module wb_interconnect_arb #(
   parameter int N_REQ = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   input  logic             ack
);

   // state     | meaning
   // ST_IDLE   | no transfer held; gnt follows the round-robin pick
   // ST_LOCKED | grant held for r_owner until ack or owner drops req
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    w_owner_next;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    w_last_next;

   logic             w_pick_vld;
   logic [IW-1:0]    w_pick_idx;
   logic [IW-1:0]    w_scan_idx;
   logic [N_REQ-1:0] w_pick_oh;
   logic [N_REQ-1:0] w_owner_oh;
   logic             w_owner_req;

   // Scan from last+1 upward with wrap; descending loop so the nearest hit wins.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      w_scan_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_scan_idx = IW'((int'(r_last) + k) % N_REQ);
         if (req[w_scan_idx]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_scan_idx;
         end
      end
   end

   assign w_pick_oh   = N_REQ'(1) << w_pick_idx;
   assign w_owner_oh  = N_REQ'(1) << r_owner;
   assign w_owner_req = req[r_owner];

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_last_next  = r_last;
      gnt          = '0;
      if (!reset) begin
         gnt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  gnt = w_pick_oh;
                  if (ack) begin
                     w_last_next = w_pick_idx;
                  end else begin
                     w_state_next = ST_LOCKED;
                     w_owner_next = w_pick_idx;
                  end
               end
            end
            ST_LOCKED: begin
               gnt = w_owner_oh & req;
               if (ack || !w_owner_req) begin
                  w_state_next = ST_IDLE;
                  w_last_next  = r_owner;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_last  <= LAST_RST;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
         r_last  <= w_last_next;
      end
   end

endmodule

// File: tb/tb_wb_interconnect_arb.sv
// Self-checking bench for wb_interconnect_arb (N_REQ=4): directed plan
// scenarios plus randomized traffic against a queue-free round-robin model.
module tb_wb_interconnect_arb;

   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] req   = '0;
   logic         ack   = 1'b0;
   logic [N-1:0] gnt;

   int n_checks = 0;
   int n_fail   = 0;

   // model: who currently holds the target (-1 = nobody) and who was served last
   int m_holder = -1;
   int m_last   = N - 1;

   wb_interconnect_arb #(.N_REQ(N)) u_dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .gnt   (gnt),
      .ack   (ack)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
      logic [N-1:0] g;
      g = '0;
      if (m_holder >= 0) begin
         if (r[m_holder]) g[m_holder] = 1'b1;
         return g;
      end
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_last + k) % N;
         if (r[i]) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic model_update(input logic [N-1:0] r, input logic a);
      logic [N-1:0] g;
      int           who;
      g = model_gnt(r);
      if (m_holder >= 0) begin
         if (a || !r[m_holder]) begin
            m_last   = m_holder;
            m_holder = -1;
         end
      end else if (g != '0) begin
         who = 0;
         for (int i = 0; i < N; i++) if (g[i]) who = i;
         if (a) m_last = who;
         else   m_holder = who;
      end
   endtask

   task automatic model_reset();
      m_holder = -1;
      m_last   = N - 1;
   endtask

   task automatic step(input logic [N-1:0] r, input logic a,
                       input logic [N-1:0] exp, input bit use_exp, input string tag);
      @(negedge clock);
      req = r;
      ack = a;
      #1;
      chk({tag, "/model"}, 32'(gnt), 32'(model_gnt(r)));
      if (use_exp) chk({tag, "/plan"}, 32'(gnt), 32'(exp));
      chk({tag, "/onehot"}, 32'($countones(gnt) <= 1), 32'd1);
      @(posedge clock);
      model_update(r, a);
   endtask

   task automatic do_reset(input logic [N-1:0] r);
      @(negedge clock);
      req   = r;
      ack   = 1'b0;
      reset = 1'b0;
      #1;
      chk("reset_gnt", 32'(gnt), 32'd0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      // plan 1: grant same cycle, hold, rotate after ack
      do_reset(4'b0101);
      step(4'b0101, 1'b0, 4'b0001, 1, "p1_first");
      for (int c = 0; c < 3; c++) step(4'b0101, 1'b0, 4'b0001, 1, "p1_hold");
      step(4'b0101, 1'b1, 4'b0001, 1, "p1_ack");
      step(4'b0101, 1'b0, 4'b0100, 1, "p1_rot");

      // plan 2: all requesting, ack every 2nd cycle
      do_reset(4'b0000);
      step(4'b1111, 1'b0, 4'b0001, 1, "p2_g0");
      step(4'b1111, 1'b1, 4'b0001, 1, "p2_g0a");
      step(4'b1111, 1'b0, 4'b0010, 1, "p2_g1");
      step(4'b1111, 1'b1, 4'b0010, 1, "p2_g1a");
      step(4'b1111, 1'b0, 4'b0100, 1, "p2_g2");
      step(4'b1111, 1'b1, 4'b0100, 1, "p2_g2a");
      step(4'b1111, 1'b0, 4'b1000, 1, "p2_g3");
      step(4'b1111, 1'b1, 4'b1000, 1, "p2_g3a");
      step(4'b1111, 1'b0, 4'b0001, 1, "p2_wrap");

      // plan 3: other request arriving mid-transfer does not disturb grant
      do_reset(4'b0000);
      step(4'b0010, 1'b0, 4'b0010, 1, "p3_lock");
      step(4'b0011, 1'b0, 4'b0010, 1, "p3_mid");
      step(4'b0011, 1'b1, 4'b0010, 1, "p3_ack");
      step(4'b0011, 1'b0, 4'b0001, 1, "p3_next");

      // plan 4: owner abandons cycle
      do_reset(4'b0000);
      step(4'b0100, 1'b0, 4'b0100, 1, "p4_lock");
      step(4'b1000, 1'b0, 4'b0000, 1, "p4_drop");
      step(4'b1000, 1'b0, 4'b1000, 1, "p4_next");

      // plan 5: zero-wait target
      do_reset(4'b0000);
      step(4'b0010, 1'b1, 4'b0010, 1, "p5_zw");
      step(4'b0011, 1'b0, 4'b0001, 1, "p5_next");

      // plan 6: asynchronous reset while locked
      do_reset(4'b0000);
      step(4'b1000, 1'b0, 4'b1000, 1, "p6_lock");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("p6_async", 32'(gnt), 32'd0);
      model_reset();
      req = 4'b1001;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("p6_release", 32'(gnt), 32'b0001);
      step(4'b1001, 1'b0, 4'b0001, 1, "p6_hold");

      // randomized traffic: requests tend to persist, occasional reset
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] r;
         logic         a;
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         else                           r = req | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         a = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 79) == 0) do_reset(r);
         else step(r, a, '0, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
